cpu_clock_controller: RTL and testbench

Parametrised successor to the CPU tick generator. Divides MAIN_CLOCK into the CPU tick with a runtime-programmable half-period. Adds a single-step mode, glitch-free divisor reload, a tick cycle counter, an optional cycle breakpoint, and one-cycle edge strobes for MAIN_CLOCK-domain logic. Sits between the top-level start/finish handshake and every CPU-internal register.

---
 rtl/cpu_clk_pkg.sv | 25 ++
 rtl/cpu_clk_half_counter.sv | 62 ++++++
 rtl/cpu_clock_controller.sv | 186 ++++++++++++++++++
 tb/tb_cpu_clock_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : cpu_clk_pkg                                        |
// | Description : Shared constants for the CPU clock controller:     |
// |               FSM state encoding, STATE port width and the       |
// |               smallest usable half-period.                       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package cpu_clk_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN         = 3'd1;
  localparam logic [STATE_W-1:0] ST_STEP_WAIT   = 3'd2;
  localparam logic [STATE_W-1:0] ST_STEP_ACTIVE = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE        = 3'd4;
  // Only reachable when the breakpoint feature is built in.
  localparam logic [STATE_W-1:0] ST_BREAK       = 3'd5;

  // A programmed half-period below this is clamped up to it.
  localparam int MIN_DIV = 1;

endpackage
`default_nettype wire

// File: rtl/cpu_clk_half_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : cpu_clk_half_counter                               |
// | Description : Half-period counter with shadow/active divisor.    |
// |               The shadow is copied to the active divisor only on |
// |               a toggle (or on request while ticking is stopped), |
// |               so a running half is never truncated.              |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module cpu_clk_half_counter
  import cpu_clk_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             imm_load_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             toggle_o
);

  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] eff_div;
  logic [CNT_W-1:0] half_last;

  // Toggle detection, shadow capture and reload-at-toggle.
  always_comb begin
    eff_div   = (active_q < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : active_q;
    half_last = eff_div - CNT_W'(1);
    toggle_o  = en_i && (cnt_q == half_last);
    // A load coinciding with a toggle lands straight in the next half.
    shadow_d  = load_i ? value_i : shadow_q;
    active_d  = (imm_load_i || toggle_o) ? shadow_d : active_q;
    cnt_d     = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = toggle_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter and divisor registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      shadow_q <= CNT_W'(DEFAULT_DIV);
      active_q <= CNT_W'(DEFAULT_DIV);
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_clock_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : cpu_clock_controller                               |
// | Description : Divides MAIN_CLOCK into the CPU TICK with a        |
// |               programmable half-period, free-run or single-step  |
// |               modes, rise/fall strobes and a tick cycle counter. |
// |               Define CPU_CLK_BREAKPOINT_EN to add the cycle      |
// |               breakpoint (BREAK_ARM / BREAK_CYCLE, BREAK state). |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module cpu_clock_controller
  import cpu_clk_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int CYCLE_W     = 32,
  parameter int DEFAULT_DIV = 8
) (
  input  logic               MAIN_CLOCK,
  input  logic               RESET,
  input  logic               START_PROCESSING_FLAG,
  input  logic               PROCESS_FINISHED,
  input  logic               MODE_STEP,
  input  logic               STEP_REQ,
  input  logic [CNT_W-1:0]   DIV_VALUE,
  input  logic               DIV_LOAD,
`ifdef CPU_CLK_BREAKPOINT_EN
  input  logic               BREAK_ARM,
  input  logic [CYCLE_W-1:0] BREAK_CYCLE,
`endif
  output logic               TICK,
  output logic               TICK_RISE,
  output logic               TICK_FALL,
  output logic [CYCLE_W-1:0] CYCLE_COUNT,
  output logic [STATE_W-1:0] STATE,
  output logic               BUSY
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               tick_q, tick_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               step_req_q;
  logic               step_edge;
  logic               busy_now;
  logic               busy_next;
  logic               half_toggle;
`ifdef CPU_CLK_BREAKPOINT_EN
  logic               brk_pend_q;
  logic               from_brk_q;
`endif

  // The counter only runs while ticking; it is held at zero otherwise.
  assign busy_now  = (state_q == ST_RUN) || (state_q == ST_STEP_ACTIVE);
  assign step_edge = STEP_REQ && !step_req_q;

  cpu_clk_half_counter #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_half_counter (
    .clk_i      (MAIN_CLOCK),
    .rst_i      (RESET),
    .en_i       (busy_now),
    .clr_i      (!busy_next),
    .imm_load_i (!busy_now),
    .load_i     (DIV_LOAD),
    .value_i    (DIV_VALUE),
    .toggle_o   (half_toggle)
  );

  // State register and STEP_REQ edge-detect history.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_req_q <= STEP_REQ;
    end
  end

  // Next-state: dropping START wins over everything, then FINISHED.
  always_comb begin
    state_d = state_q;
    if (!START_PROCESSING_FLAG) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!PROCESS_FINISHED) state_d = MODE_STEP ? ST_STEP_WAIT : ST_RUN;
        end
        ST_RUN: begin
          if (PROCESS_FINISHED) state_d = ST_DONE;
`ifdef CPU_CLK_BREAKPOINT_EN
          else if (half_toggle && tick_q && brk_pend_q) state_d = ST_BREAK;
`endif
        end
        ST_STEP_WAIT: begin
          if (PROCESS_FINISHED) state_d = ST_DONE;
          else if (step_edge)   state_d = ST_STEP_ACTIVE;
        end
        ST_STEP_ACTIVE: begin
          // The period ends with the falling toggle of the high half.
          if (PROCESS_FINISHED) state_d = ST_DONE;
          else if (half_toggle && tick_q) begin
`ifdef CPU_CLK_BREAKPOINT_EN
            state_d = from_brk_q ? ST_BREAK : ST_STEP_WAIT;
`else
            state_d = ST_STEP_WAIT;
`endif
          end
        end
        ST_DONE: state_d = ST_DONE;
`ifdef CPU_CLK_BREAKPOINT_EN
        ST_BREAK: begin
          if (PROCESS_FINISHED) state_d = ST_DONE;
          else if (!BREAK_ARM)  state_d = ST_RUN;
          else if (step_edge)   state_d = ST_STEP_ACTIVE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: TICK is forced low whenever the next state is not ticking.
  always_comb begin
    busy_next = (state_d == ST_RUN) || (state_d == ST_STEP_ACTIVE);
    tick_d    = busy_next ? (tick_q ^ half_toggle) : 1'b0;
    rise_d    = tick_d && !tick_q;
    fall_d    = !tick_d && tick_q;
    cycle_d   = cycle_q;
    if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
      cycle_d = '0;
    end else if (rise_d) begin
      cycle_d = cycle_q + CYCLE_W'(1);
    end
  end

  // Registered TICK, strobes and cycle counter.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      tick_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cycle_q <= '0;
    end else begin
      tick_q  <= tick_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cycle_q <= cycle_d;
    end
  end

`ifdef CPU_CLK_BREAKPOINT_EN
  // Breakpoint hit is latched on the matching rise and acted on at its fall;
  // a step taken from BREAK returns to BREAK.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      brk_pend_q <= 1'b0;
      from_brk_q <= 1'b0;
    end else begin
      if ((state_q == ST_RUN) && (state_d == ST_RUN) && rise_d &&
          BREAK_ARM && (cycle_d == BREAK_CYCLE)) begin
        brk_pend_q <= 1'b1;
      end else if (state_d != ST_RUN) begin
        brk_pend_q <= 1'b0;
      end
      if ((state_q == ST_BREAK) && (state_d == ST_STEP_ACTIVE)) begin
        from_brk_q <= 1'b1;
      end else if (state_d != ST_STEP_ACTIVE) begin
        from_brk_q <= 1'b0;
      end
    end
  end
`endif

  assign TICK        = tick_q;
  assign TICK_RISE   = rise_q;
  assign TICK_FALL   = fall_q;
  assign CYCLE_COUNT = cycle_q;
  assign STATE       = state_q;
  assign BUSY        = busy_now;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_cpu_clock_controller                            |
// | Description : Directed bench for cpu_clock_controller. Expected  |
// |               TICK rise times are queued ahead of time and       |
// |               popped by a monitor on every TICK_RISE.            |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_cpu_clock_controller;
  import cpu_clk_pkg::*;

  localparam int CNT_W   = 8;
  localparam int CYCLE_W = 32;

  logic               clk   = 1'b0;
  logic               rst   = 1'b1;
  logic               start = 1'b0;
  logic               fin   = 1'b0;
  logic               mode  = 1'b0;
  logic               sreq  = 1'b0;
  logic               dload = 1'b0;
  logic [CNT_W-1:0]   dval  = '0;
`ifdef CPU_CLK_BREAKPOINT_EN
  logic               arm   = 1'b0;
  logic [CYCLE_W-1:0] bcyc  = '0;
`endif
  logic               tick, tick_rise, tick_fall, busy;
  logic [CYCLE_W-1:0] count;
  logic [STATE_W-1:0] state;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int q_rise[$];

  cpu_clock_controller #(
    .CNT_W       (CNT_W),
    .CYCLE_W     (CYCLE_W),
    .DEFAULT_DIV (8)
  ) dut (
    .MAIN_CLOCK            (clk),
    .RESET                 (rst),
    .START_PROCESSING_FLAG (start),
    .PROCESS_FINISHED      (fin),
    .MODE_STEP             (mode),
    .STEP_REQ              (sreq),
    .DIV_VALUE             (dval),
    .DIV_LOAD              (dload),
`ifdef CPU_CLK_BREAKPOINT_EN
    .BREAK_ARM             (arm),
    .BREAK_CYCLE           (bcyc),
`endif
    .TICK                  (tick),
    .TICK_RISE             (tick_rise),
    .TICK_FALL             (tick_fall),
    .CYCLE_COUNT           (count),
    .STATE                 (state),
    .BUSY                  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge at which cyc == t.
  task automatic to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard consumer: every TICK_RISE must match the next queued time.
  always @(negedge clk) begin
    if (tick_rise) begin
      int exp_t;
      exp_t = (q_rise.size() > 0) ? q_rise.pop_front() : -1;
      chk("rise_time", 64'(cyc), 64'(exp_t));
    end
  end

  initial begin
    // Reset state
    to(3);
    chk("rst_tick", tick, 0);
    chk("rst_rise", tick_rise, 0);
    chk("rst_fall", tick_fall, 0);
    chk("rst_count", count, 0);
    chk("rst_state", state, ST_IDLE);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Free run, H=8: RUN entered at 5, rises every 16 from 13
    to(4); start = 1'b1; mode = 1'b0;
    q_rise = {13, 29, 45, 61, 77, 88, 94, 100, 104, 106, 108};
    to(5);  chk("run_state", state, ST_RUN); chk("run_busy", busy, 1);
    to(12); chk("run_pre_rise", tick, 0);
    to(69); chk("run_count4", count, 4);

    // Load 3 during the high half starting at 77: that half stays 8
    to(80); dval = 8'd3; dload = 1'b1;
    to(81); dload = 1'b0;
    to(84); chk("div_hold_tick", tick, 1);
    to(85); chk("div_hold_fall", tick_fall, 1); chk("div_hold_low", tick, 0);

    // Load 0 (treated as 1) during the high half starting at 100
    to(101); dval = 8'd0; dload = 1'b1;
    to(102); dload = 1'b0;
    to(105); chk("div0_tick", tick, 0);
    to(108); start = 1'b0;
    to(109);
    chk("stop_state", state, ST_IDLE);
    chk("stop_tick", tick, 0);
    chk("stop_fall", tick_fall, 1);
    chk("stop_count", count, 11);
    chk("stop_busy", busy, 0);

    // Single step, H=2; middle request lands inside STEP_ACTIVE
    dval = 8'd2; dload = 1'b1;
    to(110); dload = 1'b0;
    to(111); start = 1'b1; mode = 1'b1;
    q_rise.push_back(116); q_rise.push_back(122);
    to(112); chk("step_wait", state, ST_STEP_WAIT); chk("step_clr", count, 0);
    to(113); sreq = 1'b1;
    to(114); sreq = 1'b0; chk("step_act", state, ST_STEP_ACTIVE);
    to(115); sreq = 1'b1;
    to(116); sreq = 1'b0; chk("step_act2", state, ST_STEP_ACTIVE);
    to(118); chk("step_back", state, ST_STEP_WAIT); chk("step_low", tick, 0);
    to(119); sreq = 1'b1;
    to(120); sreq = 1'b0;
    to(125); chk("step_count", count, 2); chk("step_end", state, ST_STEP_WAIT);

    // FINISHED while TICK high
    to(126); start = 1'b0; mode = 1'b0;
    to(128); start = 1'b1;
    q_rise.push_back(131); q_rise.push_back(135);
    to(135); fin = 1'b1;
    to(136);
    chk("fin_state", state, ST_DONE);
    chk("fin_tick", tick, 0);
    chk("fin_fall", tick_fall, 1);
    chk("fin_busy", busy, 0);
    chk("fin_count", count, 2);
    to(140); chk("done_hold", state, ST_DONE); chk("done_count", count, 2);
    start = 1'b0; fin = 1'b0;
    to(141); chk("done_idle", state, ST_IDLE);

    // Reset mid-RUN with H=5, then shadow must be back to 8
    dval = 8'd5; dload = 1'b1;
    to(142); dload = 1'b0;
    to(143); start = 1'b1;
    q_rise.push_back(149);
    to(150); chk("pre_rst_tick", tick, 1); rst = 1'b1; start = 1'b0;
    to(151);
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_rise", tick_rise, 0);
    chk("mid_rst_fall", tick_fall, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_state", state, ST_IDLE);
    chk("mid_rst_busy", busy, 0);
    to(152); rst = 1'b0; start = 1'b1;
    q_rise.push_back(161);
    to(158); chk("rst_div_tick", tick, 0);
    to(161); chk("rst_div_count", count, 1);
    to(162); start = 1'b0;

`ifdef CPU_CLK_BREAKPOINT_EN
    // Breakpoint at cycle 5, H=8: RUN at 165
    to(164); bcyc = 32'd5; arm = 1'b1; start = 1'b1;
    q_rise.push_back(173); q_rise.push_back(189); q_rise.push_back(205);
    q_rise.push_back(221); q_rise.push_back(237); q_rise.push_back(259);
    to(244); chk("brk_high_state", state, ST_RUN); chk("brk_high_tick", tick, 1);
    to(245);
    chk("brk_state", state, ST_BREAK);
    chk("brk_tick", tick, 0);
    chk("brk_fall", tick_fall, 1);
    chk("brk_count", count, 5);
    to(250); chk("brk_hold", state, ST_BREAK); arm = 1'b0;
    to(259); chk("brk_resume_count", count, 6); chk("brk_resume_state", state, ST_RUN);
    to(260); start = 1'b0;
`endif

    to(270);
    chk("rise_queue_left", 64'(q_rise.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
